// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core.
// Generates stall/flush controls for PC, IF/ID, ID/EX and EX/MEM and the PC
// redirect. It resolves load-use hazards, taken branches, multi-cycle divides
// (with a watchdog) and data-memory wait states. It also keeps a saturating
// count of PC-stall cycles.
module pipe_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DIV_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4:0]            id_reg1_raddr_i,
  input  logic                  id_reg1_re_i,
  input  logic [4:0]            id_reg2_raddr_i,
  input  logic                  id_reg2_re_i,
  input  logic                  ex_mem_read_i,
  input  logic [4:0]            ex_reg_waddr_i,
  input  logic                  ex_branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] ex_branch_target_i,
  input  logic                  ex_div_start_i,
  input  logic                  div_done_i,
  input  logic                  mem_stall_i,
  output logic                  stall_pc_o,
  output logic                  stall_if_id_o,
  output logic                  stall_id_ex_o,
  output logic                  stall_ex_mem_o,
  output logic                  flush_if_id_o,
  output logic                  flush_id_ex_o,
  output logic                  flush_ex_mem_o,
  output logic                  pc_redirect_o,
  output logic [ADDR_WIDTH-1:0] pc_target_o,
  output logic                  div_busy_o,
  output logic                  div_timeout_o,
  output logic [CNT_WIDTH-1:0]  stall_cycles_o
);

  localparam int unsigned DCW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [DCW-1:0] DIV_LIMIT = DCW'(DIV_TIMEOUT);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_DIV_WAIT = 1'b1;

  logic [0:0]     state;
  logic [0:0]     state_nxt;
  logic [DCW-1:0] div_cnt;
  logic [DCW-1:0] div_cnt_nxt;
  logic           timeout_nxt;
  logic           div_timeout_q;
  logic           luh;

  // Decode reads a register that the load currently in EX has not produced yet.
  always_comb begin
    luh = ex_mem_read_i && (ex_reg_waddr_i != 5'd0) &&
          ((id_reg1_re_i && (id_reg1_raddr_i == ex_reg_waddr_i)) ||
           (id_reg2_re_i && (id_reg2_raddr_i == ex_reg_waddr_i)));
  end

  // The pulse register may still be set from the cycle before reset, so it is masked.
  always_comb begin
    div_timeout_o = div_timeout_q & ~rst_i;
  end

  // Pipeline controls and next-state selection. Every output is combinational.
  always_comb begin
    stall_pc_o     = 1'b0;
    stall_if_id_o  = 1'b0;
    stall_id_ex_o  = 1'b0;
    stall_ex_mem_o = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    flush_ex_mem_o = 1'b0;
    pc_redirect_o  = 1'b0;
    pc_target_o    = '0;
    div_busy_o     = 1'b0;
    state_nxt      = state;
    div_cnt_nxt    = div_cnt;
    timeout_nxt    = 1'b0;

    if (rst_i) begin
      flush_if_id_o  = 1'b1;
      flush_id_ex_o  = 1'b1;
      flush_ex_mem_o = 1'b1;
      state_nxt      = ST_RUN;
      div_cnt_nxt    = '0;
    end else if (state == ST_RUN) begin
      if (mem_stall_i) begin
        stall_pc_o     = 1'b1;
        stall_if_id_o  = 1'b1;
        stall_id_ex_o  = 1'b1;
        stall_ex_mem_o = 1'b1;
      end else if (ex_branch_taken_i) begin
        pc_redirect_o = 1'b1;
        pc_target_o   = ex_branch_target_i;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (ex_div_start_i) begin
        stall_pc_o     = 1'b1;
        stall_if_id_o  = 1'b1;
        stall_id_ex_o  = 1'b1;
        flush_ex_mem_o = 1'b1;
        state_nxt      = ST_DIV_WAIT;
        div_cnt_nxt    = DCW'(1);
      end else if (luh) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end
    end else begin
      div_busy_o     = 1'b1;
      stall_ex_mem_o = mem_stall_i;
      if (div_done_i && !mem_stall_i) begin
        state_nxt   = ST_RUN;
        div_cnt_nxt = '0;
      end else if (div_cnt == DIV_LIMIT) begin
        // The abort releases the front end just like a completed divide does.
        state_nxt   = ST_RUN;
        div_cnt_nxt = '0;
        timeout_nxt = 1'b1;
      end else begin
        stall_pc_o     = 1'b1;
        stall_if_id_o  = 1'b1;
        stall_id_ex_o  = 1'b1;
        flush_ex_mem_o = ~mem_stall_i;
        div_cnt_nxt    = div_cnt + DCW'(1);
      end
    end
  end

  // State, divide counter and watchdog pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_RUN;
      div_cnt       <= '0;
      div_timeout_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      div_cnt       <= div_cnt_nxt;
      div_timeout_q <= timeout_nxt;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
    end else if (stall_pc_o && (stall_cycles_o != '1)) begin
      stall_cycles_o <= stall_cycles_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl. The driver applies one input set per cycle
// and queues the outputs that the reference model expects. A monitor pops the
// queue mid-cycle and compares the expected values against the DUT outputs.
module tb_pipe_ctrl;

  localparam int unsigned TMO = 40;

  typedef struct {
    bit        rst;
    bit [4:0]  r1;
    bit        re1;
    bit [4:0]  r2;
    bit        re2;
    bit        mr;
    bit [4:0]  wa;
    bit        bt;
    bit [31:0] tg;
    bit        ds;
    bit        dd;
    bit        ms;
  } in_t;

  typedef struct {
    logic [3:0]  stall;   // {pc, if_id, id_ex, ex_mem}
    logic [2:0]  flush;   // {if_id, id_ex, ex_mem}
    logic        redir;
    logic [31:0] tgt;
    logic        busy;
    logic        tmo;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  id_reg1_raddr_i, id_reg2_raddr_i, ex_reg_waddr_i;
  logic        id_reg1_re_i, id_reg2_re_i, ex_mem_read_i;
  logic        ex_branch_taken_i, ex_div_start_i, div_done_i, mem_stall_i;
  logic [31:0] ex_branch_target_i;
  logic        stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o;
  logic        flush_if_id_o, flush_id_ex_o, flush_ex_mem_o;
  logic        pc_redirect_o, div_busy_o, div_timeout_o;
  logic [31:0] pc_target_o;
  logic [7:0]  stall_cycles_o;

  int n_chk  = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_pop  = 0;
  int cyc_no = 0;
  exp_t q[$];

  // reference model state
  bit dividing   = 1'b0;
  int div_cycles = 0;
  bit pulse_due  = 1'b0;
  int stall_cnt  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .ADDR_WIDTH(32),
    .DIV_TIMEOUT(TMO),
    .CNT_WIDTH(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .id_reg1_raddr_i(id_reg1_raddr_i),
    .id_reg1_re_i(id_reg1_re_i),
    .id_reg2_raddr_i(id_reg2_raddr_i),
    .id_reg2_re_i(id_reg2_re_i),
    .ex_mem_read_i(ex_mem_read_i),
    .ex_reg_waddr_i(ex_reg_waddr_i),
    .ex_branch_taken_i(ex_branch_taken_i),
    .ex_branch_target_i(ex_branch_target_i),
    .ex_div_start_i(ex_div_start_i),
    .div_done_i(div_done_i),
    .mem_stall_i(mem_stall_i),
    .stall_pc_o(stall_pc_o),
    .stall_if_id_o(stall_if_id_o),
    .stall_id_ex_o(stall_id_ex_o),
    .stall_ex_mem_o(stall_ex_mem_o),
    .flush_if_id_o(flush_if_id_o),
    .flush_id_ex_o(flush_id_ex_o),
    .flush_ex_mem_o(flush_ex_mem_o),
    .pc_redirect_o(pc_redirect_o),
    .pc_target_o(pc_target_o),
    .div_busy_o(div_busy_o),
    .div_timeout_o(div_timeout_o),
    .stall_cycles_o(stall_cycles_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, exp_v);
    end
  endtask

  // Reference model: expected outputs for this cycle, then advance the model.
  function automatic exp_t model(input in_t s);
    exp_t e;
    bit   hazard;
    bit   pulse_next;
    e.stall = 4'b0000;
    e.flush = 3'b000;
    e.redir = 1'b0;
    e.tgt   = 32'd0;
    e.busy  = 1'b0;
    e.tmo   = pulse_due && !s.rst;
    e.cnt   = 8'(stall_cnt);
    pulse_next = 1'b0;
    if (s.rst) begin
      e.flush    = 3'b111;
      dividing   = 1'b0;
      div_cycles = 0;
      stall_cnt  = 0;
    end else begin
      hazard = s.mr && (s.wa != 0) &&
               ((s.re1 && s.r1 == s.wa) || (s.re2 && s.r2 == s.wa));
      if (!dividing) begin
        if (s.ms) begin
          e.stall = 4'b1111;
        end else if (s.bt) begin
          e.redir = 1'b1;
          e.tgt   = s.tg;
          e.flush = 3'b110;
        end else if (s.ds) begin
          e.stall    = 4'b1110;
          e.flush    = 3'b001;
          dividing   = 1'b1;
          div_cycles = 1;
        end else if (hazard) begin
          e.stall = 4'b1100;
          e.flush = 3'b010;
        end
      end else begin
        e.busy = 1'b1;
        if (s.dd && !s.ms) begin
          dividing = 1'b0;
        end else if (div_cycles == TMO) begin
          e.stall    = {3'b000, s.ms};
          dividing   = 1'b0;
          pulse_next = 1'b1;
        end else begin
          e.stall    = {3'b111, s.ms};
          e.flush    = {2'b00, !s.ms};
          div_cycles = div_cycles + 1;
        end
      end
      if (e.stall[3] && stall_cnt < 255) stall_cnt = stall_cnt + 1;
    end
    pulse_due = pulse_next;
    return e;
  endfunction

  task automatic apply(input in_t s);
    rst_i              = s.rst;
    id_reg1_raddr_i    = s.r1;
    id_reg1_re_i       = s.re1;
    id_reg2_raddr_i    = s.r2;
    id_reg2_re_i       = s.re2;
    ex_mem_read_i      = s.mr;
    ex_reg_waddr_i     = s.wa;
    ex_branch_taken_i  = s.bt;
    ex_branch_target_i = s.tg;
    ex_div_start_i     = s.ds;
    div_done_i         = s.dd;
    mem_stall_i        = s.ms;
  endtask

  task automatic cyc(input in_t s);
    @(posedge clk);
    #1;
    apply(s);
    q.push_back(model(s));
    n_push++;
  endtask

  task automatic rep(input in_t s, input int n);
    for (int i = 0; i < n; i++) cyc(s);
  endtask

  // Monitor: compare the DUT outputs with the queued expectation in mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_pop++;
        chk("stalls", 32'({stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o}), 32'(e.stall));
        chk("flushes", 32'({flush_if_id_o, flush_id_ex_o, flush_ex_mem_o}), 32'(e.flush));
        chk("pc_redirect", 32'(pc_redirect_o), 32'(e.redir));
        chk("pc_target", pc_target_o, e.tgt);
        chk("div_busy", 32'(div_busy_o), 32'(e.busy));
        chk("div_timeout", 32'(div_timeout_o), 32'(e.tmo));
        chk("stall_cycles", 32'(stall_cycles_o), 32'(e.cnt));
        cyc_no++;
      end
    end
  end

  initial begin
    in_t z, s;
    z = '{default: 0};
    s = z;
    s.rst = 1'b1;
    apply(s);
    rep(s, 2);
    rep(z, 2);

    // load-use: rs1 hazard, then waddr=0 and re=0 variants, then rs2 hazard
    s = z; s.mr = 1'b1; s.wa = 5'd5; s.r1 = 5'd5; s.re1 = 1'b1;
    cyc(s); cyc(z);
    s.wa = 5'd0; s.r1 = 5'd0; cyc(s);
    s.wa = 5'd5; s.r1 = 5'd5; s.re1 = 1'b0; cyc(s);
    s = z; s.mr = 1'b1; s.wa = 5'd7; s.r2 = 5'd7; s.re2 = 1'b1; cyc(s); cyc(z);

    // taken branch beats a simultaneous load-use
    s = z; s.mr = 1'b1; s.wa = 5'd3; s.r1 = 5'd3; s.re1 = 1'b1;
    s.bt = 1'b1; s.tg = 32'h0000_0100;
    cyc(s); cyc(z);

    // 33-cycle divide from a cleared counter
    s = z; s.rst = 1'b1; cyc(s);
    s = z; s.ds = 1'b1;
    rep(s, 33);
    s.dd = 1'b1; cyc(s);
    rep(z, 2);

    // watchdog: done never arrives
    s = z; s.ds = 1'b1;
    rep(s, TMO + 1);
    rep(z, 3);

    // memory stall holds a pending branch
    s = z; s.bt = 1'b1; s.tg = 32'hdead_beec; s.ms = 1'b1;
    rep(s, 3);
    s.ms = 1'b0; cyc(s);
    cyc(z);

    // done during a memory stall is deferred
    s = z; s.ds = 1'b1;
    rep(s, 3);
    s.dd = 1'b1; s.ms = 1'b1; rep(s, 3);
    s.ms = 1'b0; cyc(s);
    rep(z, 2);

    // reset in the middle of a divide
    s = z; s.ds = 1'b1;
    rep(s, 6);
    s = z; s.rst = 1'b1; cyc(s);
    rep(z, 2);

    // counter saturation
    s = z; s.ms = 1'b1;
    rep(s, 300);
    rep(z, 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 149) == 0);
      s.r1  = 5'($urandom_range(0, 3));
      s.re1 = 1'($urandom_range(0, 1));
      s.r2  = 5'($urandom_range(0, 3));
      s.re2 = 1'($urandom_range(0, 1));
      s.mr  = 1'($urandom_range(0, 1));
      s.wa  = 5'($urandom_range(0, 3));
      s.bt  = ($urandom_range(0, 5) == 0);
      s.tg  = $urandom;
      s.ds  = ($urandom_range(0, 4) == 0);
      s.dd  = ($urandom_range(0, 3) == 0);
      s.ms  = ($urandom_range(0, 5) == 0);
      cyc(s);
    end
    rep(z, 2);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(n_pop), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core.
- Sits beside the decode stage and drives the stall/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It also drives the PC redirect.
- Resolves load-use hazards from decode's register-read requests, taken branches/jumps resolved in EX, multi-cycle DIV/REM in EX, and data-memory wait states.
- Keeps a divide watchdog and a stall-cycle performance counter.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- DIV_TIMEOUT, 64, max DIV_WAIT cycles before forced abort (>=2).
- CNT_WIDTH, 32, width of the stall performance counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- id_reg1_raddr_i  in  5  rs1 address requested by decode.
- id_reg1_re_i  in  1  rs1 read enable from decode.
- id_reg2_raddr_i  in  5  rs2 address requested by decode.
- id_reg2_re_i  in  1  rs2 read enable from decode.
- ex_mem_read_i  in  1  instruction in EX is a load.
- ex_reg_waddr_i  in  5  destination register of the EX instruction.
- ex_branch_taken_i  in  1  EX resolved a taken branch/JAL/JALR.
- ex_branch_target_i  in  ADDR_WIDTH  redirect target.
- ex_div_start_i  in  1  EX holds DIV/DIVU/REM/REMU (level, held while EX frozen).
- div_done_i  in  1  divider result valid (level, held until accepted).
- mem_stall_i  in  1  data memory not ready.
- stall_pc_o  out  1  hold PC.
- stall_if_id_o  out  1  hold IF/ID.
- stall_id_ex_o  out  1  hold ID/EX.
- stall_ex_mem_o  out  1  hold EX/MEM.
- flush_if_id_o  out  1  load NOP into IF/ID.
- flush_id_ex_o  out  1  load NOP into ID/EX.
- flush_ex_mem_o  out  1  load NOP into EX/MEM.
- pc_redirect_o  out  1  load PC from pc_target_o.
- pc_target_o  out  ADDR_WIDTH  redirect address.
- div_busy_o  out  1  state is DIV_WAIT.
- div_timeout_o  out  1  one-cycle pulse on watchdog abort.
- stall_cycles_o  out  CNT_WIDTH  count of cycles with stall_pc_o=1, saturating.

Behaviour:
- Reset: clock and reset as decided (single clk_i; rst_i synchronous, active-high). While rst_i=1, outputs are combinationally forced: all stall_* = 0, flush_if_id_o = flush_id_ex_o = flush_ex_mem_o = 1, pc_redirect_o = 0, pc_target_o = 0, div_busy_o = 0, div_timeout_o = 0. On the first clock edge with rst_i=1: state <= RUN, div_cnt <= 0, stall_cycles_o <= 0, div_timeout_o register <= 0.
- Outputs are combinational from state and inputs, with zero latency; only state, div_cnt, stall_cycles_o and div_timeout_o are registered.
- Load-use hazard: luh = ex_mem_read_i & (ex_reg_waddr_i != 0) & ((id_reg1_re_i & id_reg1_raddr_i == ex_reg_waddr_i) | (id_reg2_re_i & id_reg2_raddr_i == ex_reg_waddr_i)).
- RUN, evaluated in strict priority:
  1. mem_stall_i: all four stall_* = 1, no flush, no redirect. State holds; pending branch/div is acted on when the stall drops, since EX inputs are held.
  2. ex_branch_taken_i: pc_redirect_o = 1, pc_target_o = ex_branch_target_i, flush_if_id_o = flush_id_ex_o = 1. The wrong-path load-use is ignored.
  3. ex_div_start_i: stall_pc/if_id/id_ex = 1, flush_ex_mem_o = 1; next state DIV_WAIT, div_cnt <= 1.
  4. luh: stall_pc_o = stall_if_id_o = 1, flush_id_ex_o = 1, for exactly the cycle luh is true (one bubble).
  5. Otherwise all outputs 0.
- DIV_WAIT:
  - stall_pc/if_id/id_ex = 1 always; div_busy_o = 1.
  - stall_ex_mem_o = mem_stall_i; flush_ex_mem_o = ~mem_stall_i.
  - div_done_i & ~mem_stall_i: in that cycle stall_pc/if_id/id_ex = 0 and flush_ex_mem_o = 0, so the div result enters EX/MEM. Next state RUN, div_cnt <= 0.
  - Else if div_cnt == DIV_TIMEOUT: next state RUN, div_timeout_o pulses the following cycle. In that cycle EX behaves as on done (EX result undefined); pipeline continues.
  - Else div_cnt increments.
  - Branch and load-use inputs are ignored in DIV_WAIT.
- pc_target_o = 0 whenever pc_redirect_o = 0.
- stall_cycles_o increments when stall_pc_o = 1 and the value is not all-ones; it holds at 2^CNT_WIDTH-1.
- Reset mid-DIV_WAIT returns to RUN next edge with no timeout pulse.

Test Plan:
- Load-use: EX = lw x5 (ex_mem_read_i=1, waddr=5), ID reads rs1=5 re=1 → exactly 1 cycle of stall_pc=stall_if_id=flush_id_ex=1; with waddr=0 or re=0 → no stall; stall_cycles_o +1.
- Branch priority: ex_branch_taken_i=1, target=0x0000_0100, simultaneous luh → pc_redirect_o=1, pc_target_o=0x100, flush_if_id=flush_id_ex=1, stall_pc=0.
- Divide: ex_div_start_i=1, div_done_i after 33 cycles → div_busy_o high 33 cycles, stall_pc continuous, released in done cycle; state RUN next; stall_cycles_o = 33.
- Timeout: DIV_TIMEOUT=8, div_done_i never → exit after div_cnt=8, div_timeout_o single-cycle pulse, div_busy_o=0.
- Mem stall: mem_stall_i=1 for 3 cycles with ex_branch_taken_i=1 → all stalls 1, no redirect for 3 cycles, redirect on 4th; in DIV_WAIT with done+mem_stall → remain DIV_WAIT until mem_stall_i=0.
- Reset: rst_i=1 during DIV_WAIT → flushes=1, stalls=0; next cycle state RUN, stall_cycles_o=0, no timeout pulse.
